// File: rtl/freeze_ctrl.sv
// Pipeline freeze controller: per-channel IDLE/WAIT request trackers drive one global freeze_stall.
// Define FREEZE_PERF_EN to build the frozen-cycle performance counter; otherwise freeze_cycles is tied to 0.
module freeze_ctrl #(
  parameter int NUM_PORTS      = 2,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       req,
  input  logic [NUM_PORTS-1:0]       resp,
  output logic                       freeze_stall,
  output logic [NUM_PORTS-1:0]       pending,
  output logic [NUM_PORTS-1:0]       timeout,
  output logic [NUM_PORTS*CNT_W-1:0] wait_cnt,
  output logic [31:0]                freeze_cycles
);

  localparam logic [0:0]       ST_IDLE     = 1'b0;
  localparam logic [0:0]       ST_WAIT     = 1'b1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [NUM_PORTS-1:0] w_stall_ch;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;

    // A request that completes in WAIT is not re-accepted in the same cycle.
    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_timeout_nxt = r_timeout;
      case (r_state)
        ST_IDLE: begin
          if (req[g] && !resp[g]) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        default: begin
          if (resp[g]) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_timeout_nxt = 1'b0;
          end else begin
            w_cnt_nxt = sat_inc(r_cnt);
          end
        end
      endcase
      if (w_state_nxt == ST_WAIT && w_cnt_nxt == TIMEOUT_VAL) begin
        w_timeout_nxt = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_timeout <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_timeout <= w_timeout_nxt;
      end
    end

    // Same-cycle stall: a missing response freezes immediately, no added latency.
    assign w_stall_ch[g]                = ~resp[g] & (req[g] | (r_state == ST_WAIT));
    assign pending[g]                   = (r_state == ST_WAIT);
    assign timeout[g]                   = r_timeout;
    assign wait_cnt[g*CNT_W +: CNT_W]   = r_cnt;
  end

  assign freeze_stall = ~rst & (|w_stall_ch);

`ifdef FREEZE_PERF_EN
  logic [31:0] r_freeze_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_freeze_cycles <= '0;
    end else if (freeze_stall) begin
      r_freeze_cycles <= r_freeze_cycles + 32'd1;
    end
  end

  assign freeze_cycles = r_freeze_cycles;
`else
  assign freeze_cycles = '0;
`endif

endmodule

// File: tb/tb_freeze_ctrl.sv
// Directed bench for freeze_ctrl (2 channels, CNT_W=8, TIMEOUT_CYCLES=5).
module tb_freeze_ctrl;
  localparam int NP = 2;
  localparam int CW = 8;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     req;
  logic [NP-1:0]     resp;
  logic              freeze_stall;
  logic [NP-1:0]     pending;
  logic [NP-1:0]     timeout;
  logic [NP*CW-1:0]  wait_cnt;
  logic [31:0]       freeze_cycles;

  int n_vec = 0;
  int n_err = 0;
  int exp_fc = 0;

  freeze_ctrl #(.NUM_PORTS(NP), .CNT_W(CW), .TIMEOUT_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .req(req), .resp(resp),
    .freeze_stall(freeze_stall), .pending(pending), .timeout(timeout),
    .wait_cnt(wait_cnt), .freeze_cycles(freeze_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fc_exp();
`ifdef FREEZE_PERF_EN
    return 32'(exp_fc);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    // Reset with both requests active and no responses
    rst = 1'b1; req = 2'b11; resp = 2'b00;
    #1;
    chk("rst_stall0", {31'd0, freeze_stall}, 32'd0);
    tick();
    chk("rst_stall1", {31'd0, freeze_stall}, 32'd0);
    tick();
    chk("rst_pending", {30'd0, pending}, 32'd0);
    chk("rst_timeout", {30'd0, timeout}, 32'd0);
    chk("rst_wait_cnt", {16'd0, wait_cnt}, 32'd0);
    chk("rst_fc", freeze_cycles, 32'd0);
    rst = 1'b0; req = 2'b00; resp = 2'b00;
    tick();

    // Zero-latency hits on both channels
    req = 2'b11; resp = 2'b11;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("hit_stall", {31'd0, freeze_stall}, 32'd0);
      tick();
      chk("hit_pending", {30'd0, pending}, 32'd0);
    end
    chk("hit_fc", freeze_cycles, fc_exp());

    // Channel 0 miss, response 4 cycles later
    req = 2'b01; resp = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("miss0_stall", {31'd0, freeze_stall}, 32'd1);
      tick();
      exp_fc++;
      chk("miss0_cnt", {24'd0, wait_cnt[7:0]}, 32'(k));
      chk("miss0_pending", {30'd0, pending}, 32'b01);
    end
    resp = 2'b01;
    #1;
    chk("miss0_release", {31'd0, freeze_stall}, 32'd0);
    tick();
    chk("miss0_cnt_clr", {24'd0, wait_cnt[7:0]}, 32'd0);
    chk("miss0_pending_clr", {30'd0, pending}, 32'd0);
    req = 2'b00; resp = 2'b00;
    chk("miss0_fc", freeze_cycles, fc_exp());

    // Overlapping misses: ch0 responds at +3, ch1 at +6
    for (int c = 0; c <= 6; c++) begin
      req  = {1'b1, (c <= 3)};
      resp = {(c == 6), (c == 3)};
      #1;
      chk("ovl_stall", {31'd0, freeze_stall}, (c < 6) ? 32'd1 : 32'd0);
      tick();
      if (c < 6) exp_fc++;
      chk("ovl_pending", {30'd0, pending}, {30'd0, (c < 6), (c < 3)});
      chk("ovl_cnt1", {24'd0, wait_cnt[15:8]}, (c < 6) ? 32'(c + 1) : 32'd0);
    end
    req = 2'b00; resp = 2'b00;
    chk("ovl_fc", freeze_cycles, fc_exp());

    // Timeout on channel 1 after 5 wait edges, sticky until response
    req = 2'b10; resp = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("to_stall", {31'd0, freeze_stall}, 32'd1);
      tick();
      exp_fc++;
      chk("to_cnt1", {24'd0, wait_cnt[15:8]}, 32'(k));
      chk("to_flag", {30'd0, timeout}, (k >= 5) ? 32'b10 : 32'b00);
    end
    resp = 2'b10;
    #1;
    chk("to_release", {31'd0, freeze_stall}, 32'd0);
    tick();
    chk("to_flag_clr", {30'd0, timeout}, 32'd0);
    chk("to_cnt_clr", {24'd0, wait_cnt[15:8]}, 32'd0);
    chk("to_pending_clr", {30'd0, pending}, 32'd0);
    req = 2'b00; resp = 2'b00;
    chk("to_fc", freeze_cycles, fc_exp());

    // Saturation of the channel 0 counter at 255
    req = 2'b01; resp = 2'b00;
    for (int k = 1; k <= 260; k++) begin
      tick();
      exp_fc++;
    end
    chk("sat_cnt0", {24'd0, wait_cnt[7:0]}, 32'd255);
    chk("sat_timeout", {30'd0, timeout}, 32'b01);
    chk("sat_fc", freeze_cycles, fc_exp());
    resp = 2'b01;
    tick();
    req = 2'b00; resp = 2'b00;
    chk("sat_cnt_clr", {24'd0, wait_cnt[7:0]}, 32'd0);

    // Reset mid-wait, then a stray response on channel 1
    req = 2'b10; resp = 2'b00;
    for (int k = 1; k <= 3; k++) tick();
    chk("rmw_pending", {30'd0, pending}, 32'b10);
    chk("rmw_cnt1", {24'd0, wait_cnt[15:8]}, 32'd3);
    rst = 1'b1;
    #1;
    chk("rmw_rst_stall", {31'd0, freeze_stall}, 32'd0);
    tick();
    exp_fc = 0;
    chk("rmw_pending_rst", {30'd0, pending}, 32'd0);
    chk("rmw_cnt_rst", {16'd0, wait_cnt}, 32'd0);
    chk("rmw_fc_rst", freeze_cycles, 32'd0);
    rst = 1'b0; req = 2'b00; resp = 2'b10;
    #1;
    chk("stray_stall", {31'd0, freeze_stall}, 32'd0);
    tick();
    resp = 2'b00;
    chk("stray_pending", {30'd0, pending}, 32'd0);
    chk("stray_cnt", {16'd0, wait_cnt}, 32'd0);
    chk("stray_timeout", {30'd0, timeout}, 32'd0);
    #1;
    chk("idle_stall", {31'd0, freeze_stall}, 32'd0);
    tick();
    chk("idle_fc", freeze_cycles, fc_exp());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
